ov7670_capture: RTL and testbench
=================================

Name: ov7670_capture

Overview:
- Pixel-capture front end for an OV7670 camera running QVGA (320x240), RGB444 output (two bytes per pixel).
- Runs in the camera pixel-clock domain.
- Assembles byte pairs into 12-bit pixels and emits a write strobe plus linear frame-buffer address to a dual-port frame RAM.
- Downstream VGA reader consumes the RAM on its own clock.

Parameters:
- ADDR_W, 17, frame-buffer address width.
- MAX_PIXELS, 76800, pixels per frame (320x240); last valid address is MAX_PIXELS-1.

Ports:
- pclk  input  1  camera pixel clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- vsync  input  1  camera frame sync, active high (high = vertical blanking / frame restart).
- href  input  1  line valid, active high; d carries pixel bytes while high.
- d  input  8  camera data byte.
- addr  output  ADDR_W  frame-buffer write address, valid when we=1.
- dout  output  12  pixel {R[3:0],G[3:0],B[3:0]}, valid when we=1.
- we  output  1  one-cycle write strobe.

Behaviour:
- Reset (rst_n=0, async): addr=0, dout=0, we=0, byte phase=0, full flag=0, latched high byte=0. All outputs registered.
- Inputs sampled on rising pclk; no internal input synchroniser (same clock domain as camera).
- Byte format (RGB444 "xR GB"):
  - First byte of pair: d[3:0]=R, d[7:4] ignored.
  - Second byte: d[7:4]=G, d[3:0]=B.
- Byte phase:
  - Cleared whenever href=0.
  - Toggles on every pclk edge with href=1.
  - Phase 0 edge: latch d[3:0] as R.
  - Phase 1 edge: dout <= {R_latched, d[7:4], d[3:0]}; we <= 1 (unless full).
- Latency: we and dout are asserted in the cycle immediately after the edge sampling the second byte. addr during that cycle = address of that pixel.
- Address advance:
  - addr increments by 1 on the edge ending a we cycle.
  - Pixel k of a frame (0-based) is written at address k.
- we low in every cycle except one following a completed byte pair. Max one strobe per 2 pclk.
- Odd byte count in a line: trailing lone byte discarded; the phase reset at href=0 realigns the next line.
- Frame full:
  - After the write to MAX_PIXELS-1, full flag sets and addr holds at MAX_PIXELS-1 (no wrap).
  - Further pairs produce no we until the next vsync.
- vsync=1 (sampled): addr <= 0, phase <= 0, full <= 0, we <= 0.
  - Overrides any pixel completion in the same cycle: pair dropped.
  - href ignored while vsync=1.
- dout holds its last value when we=0.
- Reset mid-frame: immediate return to reset state. Capture resumes from address 0 on the next pair after release. No vsync required, but alignment is only guaranteed after a vsync.

Test Plan:
- Reset: rst_n=0 with random d/href toggling -> addr=0, dout=0, we=0 throughout; release with vsync=1 -> still we=0.
- Single pixel: vsync pulse, then href=1 with bytes 0x0A, 0x5C -> exactly one we pulse one cycle after the 0x5C edge, with dout=0xA5C, addr=0; addr=1 the following cycle.
- Line of 4 pixels: bytes 0x01,0x23,0x04,0x56,0x07,0x89,0x0F,0xFF -> we pulses at addr 0..3 with dout 0x123, 0x456, 0x789, 0xFFF; no two consecutive we cycles.
- Odd byte/realignment: line of 3 bytes (0x03, 0x21, 0x0E), href low, next line 0x0B, 0xCD -> writes 0x321 then 0xBCD at consecutive addresses; the lone 0x0E is dropped.
- Full frame: 76800 pixel pairs plus 2 extra pairs -> last we at addr 76799, extra pairs give no we, addr stays 76799; vsync then one pair -> write at addr 0.
- Vsync collision: vsync asserted on the same edge as the second byte -> no we, addr=0 next cycle.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 QVGA RGB444 capture: pairs camera bytes into 12-bit pixels and
// produces a write strobe with a linear frame-buffer address.
module ov7670_capture #(
    parameter int ADDR_W     = 17,
    parameter int MAX_PIXELS = 76800
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_PIXELS - 1);

    typedef enum logic {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    phase_t     phase;
    logic       full;
    logic [3:0] red;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            dout  <= '0;
            we    <= 1'b0;
            phase <= PH_FIRST;
            full  <= 1'b0;
            red   <= '0;
        end else if (vsync) begin
            // Frame restart wins over any pair completing on this edge.
            addr  <= '0;
            phase <= PH_FIRST;
            full  <= 1'b0;
            we    <= 1'b0;
        end else begin
            we <= 1'b0;
            // The edge closing a write cycle moves to the next address, or
            // marks the frame full once the last address has been written.
            if (we) begin
                if (addr == LAST_ADDR)
                    full <= 1'b1;
                else
                    addr <= addr + 1'b1;
            end
            if (!href) begin
                phase <= PH_FIRST;
            end else if (phase == PH_FIRST) begin
                phase <= PH_SECOND;
                red   <= d[3:0];
            end else begin
                phase <= PH_FIRST;
                if (!full) begin
                    dout <= {red, d};
                    we   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: byte streams are checked against a frame-level
// model that lists the (address, pixel) writes each line should produce.
module tb_ov7670_capture;

    localparam int ADDR_W = 17;
    localparam int MAXP   = 100;

    typedef logic [7:0] bq_t[$];
    typedef logic [ADDR_W+11:0] wr_t;

    logic              pclk = 1'b0;
    logic              rst_n;
    logic              vsync;
    logic              href;
    logic [7:0]        d;
    logic [ADDR_W-1:0] addr;
    logic [11:0]       dout;
    logic              we;

    int errors = 0;
    int checks = 0;

    wr_t exp_q[$];
    wr_t act_q[$];
    int  model_k;
    int  b2b = 0;
    logic prev_we = 1'b0;

    ov7670_capture #(.ADDR_W(ADDR_W), .MAX_PIXELS(MAXP)) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .vsync (vsync),
        .href  (href),
        .d     (d),
        .addr  (addr),
        .dout  (dout),
        .we    (we)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (we) act_q.push_back({addr, dout});
        if (we && prev_we) b2b++;
        prev_we = we;
    end

    // Reference: every complete byte pair in a line is one pixel at the next
    // frame index, dropped once the frame already holds MAXP pixels.
    function automatic void model_restart();
        model_k = 0;
    endfunction

    function automatic void model_line(input bq_t b);
        for (int i = 0; i + 1 < b.size(); i += 2) begin
            if (model_k < MAXP) begin
                exp_q.push_back({ADDR_W'(model_k), b[i][3:0], b[i+1]});
                model_k++;
            end
        end
    endfunction

    task automatic tick(input logic v, input logic h, input logic [7:0] dd);
        vsync = v;
        href  = h;
        d     = dd;
        @(posedge pclk);
        #1;
    endtask

    task automatic send_line(input bq_t b);
        model_line(b);
        foreach (b[i]) tick(1'b0, 1'b1, b[i]);
        repeat (1 + $urandom_range(2)) tick(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic do_vsync();
        repeat (2) tick(1'b1, 1'($urandom), 8'($urandom));
        tick(1'b0, 1'b0, 8'h00);
        model_restart();
        act_q.delete();
        exp_q.delete();
        b2b = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'($urandom), 8'($urandom));
            checks++;
            if (addr !== '0 || dout !== 12'h000 || we !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: addr=%0d dout=%h we=%b, need 0/000/0", addr, dout, we);
            end
        end
        vsync = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom), 8'($urandom));
            checks++;
            if (we !== 1'b0 || addr !== '0) begin
                errors++;
                $display("FAIL reset_release: we=%b addr=%0d, need 0/0", we, addr);
            end
        end
        tick(1'b0, 1'b0, 8'h00);
        model_restart();
        act_q.delete();
    endtask

    task automatic test_single();
        do_vsync();
        tick(1'b0, 1'b1, 8'h0A);
        checks++;
        if (we !== 1'b0) begin
            errors++;
            $display("FAIL single_first_byte: we=%b, need 0", we);
        end
        tick(1'b0, 1'b1, 8'h5C);
        checks++;
        if (we !== 1'b1 || dout !== 12'hA5C || addr !== '0) begin
            errors++;
            $display("FAIL single_write: we=%b dout=%h addr=%0d, need 1/a5c/0", we, dout, addr);
        end
        tick(1'b0, 1'b0, 8'h00);
        checks++;
        if (we !== 1'b0 || addr !== ADDR_W'(1) || dout !== 12'hA5C) begin
            errors++;
            $display("FAIL single_after: we=%b addr=%0d dout=%h, need 0/1/a5c", we, addr, dout);
        end
        tick(1'b0, 1'b0, 8'h00);
        checks++;
        if (act_q.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes, need 1", act_q.size());
        end
    endtask

    task automatic test_line();
        bq_t b;
        do_vsync();
        b = {8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0F, 8'hFF};
        send_line(b);
        b = {8'h03, 8'h21, 8'h0E};
        send_line(b);
        b = {8'h0B, 8'hCD};
        send_line(b);
        checks++;
        if (act_q.size() != 6 || exp_q.size() != 6) begin
            errors++;
            $display("FAIL line_count: got %0d writes, need 6 (model %0d)", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL line_write[%0d]: addr/pix=%h, need %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (b2b != 0) begin
            errors++;
            $display("FAIL line_b2b: %0d back-to-back strobes, need 0", b2b);
        end
    endtask

    task automatic test_random();
        bq_t b;
        for (int f = 0; f < 3; f++) begin
            do_vsync();
            for (int l = 0; l < 6; l++) begin
                b.delete();
                repeat ($urandom_range(25)) b.push_back(8'($urandom));
                send_line(b);
            end
            checks++;
            if (act_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_count[%0d]: got %0d writes, need %0d", f, act_q.size(), exp_q.size());
            end
            for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (act_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_write[%0d.%0d]: addr/pix=%h, need %h", f, i, act_q[i], exp_q[i]);
                end
            end
            checks++;
            if (b2b != 0) begin
                errors++;
                $display("FAIL rand_b2b[%0d]: %0d back-to-back strobes, need 0", f, b2b);
            end
        end
    endtask

    task automatic test_full();
        bq_t b;
        int  pairs;
        int  n;
        do_vsync();
        pairs = 0;
        while (pairs < MAXP + 2) begin
            n = 1 + $urandom_range(9);
            if (n > MAXP + 2 - pairs) n = MAXP + 2 - pairs;
            b.delete();
            repeat (2 * n) b.push_back(8'($urandom));
            send_line(b);
            pairs += n;
        end
        checks++;
        if (act_q.size() != MAXP) begin
            errors++;
            $display("FAIL full_count: got %0d writes, need %0d", act_q.size(), MAXP);
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_write[%0d]: addr/pix=%h, need %h", i, act_q[i], exp_q[i]);
            end
        end
        checks++;
        if (addr !== ADDR_W'(MAXP - 1) || we !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: addr=%0d we=%b, need %0d/0", addr, we, MAXP - 1);
        end
        do_vsync();
        b = {8'h06, 8'h9A};
        send_line(b);
        checks++;
        if (act_q.size() != 1 || act_q[0] !== {ADDR_W'(0), 12'h69A}) begin
            errors++;
            $display("FAIL full_restart: %0d writes, first=%h, need 1 at addr 0 pix 69a",
                     act_q.size(), act_q.size() > 0 ? act_q[0] : '0);
        end
    endtask

    task automatic test_vsync_collision();
        bq_t b;
        do_vsync();
        b = {8'h02, 8'h46, 8'h08, 8'hAC};
        send_line(b);
        tick(1'b0, 1'b1, 8'h0A);
        tick(1'b1, 1'b1, 8'h5C);
        checks++;
        if (we !== 1'b0 || addr !== '0) begin
            errors++;
            $display("FAIL vsync_collide: we=%b addr=%0d, need 0/0", we, addr);
        end
        tick(1'b0, 1'b0, 8'h00);
        model_restart();
        b = {8'h01, 8'h23};
        send_line(b);
        checks++;
        if (act_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL vsync_count: got %0d writes, need %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (act_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL vsync_write[%0d]: addr/pix=%h, need %h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        bq_t b;
        do_vsync();
        b = {8'h0C, 8'h33, 8'h0D, 8'h44, 8'h0E};
        foreach (b[i]) tick(1'b0, 1'b1, b[i]);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (addr !== '0 || dout !== 12'h000 || we !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: addr=%0d dout=%h we=%b, need 0/000/0", addr, dout, we);
        end
        tick(1'b0, 1'b1, 8'h55);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 8'h00);
        model_restart();
        act_q.delete();
        exp_q.delete();
        b = {8'h07, 8'hBE};
        send_line(b);
        checks++;
        if (act_q.size() != 1 || act_q[0] !== {ADDR_W'(0), 12'h7BE}) begin
            errors++;
            $display("FAIL async_resume: %0d writes, first=%h, need 1 at addr 0 pix 7be",
                     act_q.size(), act_q.size() > 0 ? act_q[0] : '0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        d     = 8'h00;
        model_restart();
        test_reset();
        test_single();
        test_line();
        test_random();
        test_full();
        test_vsync_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
